// File: rtl/sram_banked_pipe.sv
// Address-interleaved multi-bank SRAM model: one read and one write per cycle to different banks,
// byte-masked writes, configurable read latency and an optional post-reset zero-fill.
module sram_banked_pipe #(
    parameter int SRAM_DEPTH_BIT = 10,
    parameter int NUM_BANK_BIT   = 2,
    parameter int SRAM_WIDTH     = 64,
    parameter int READ_LATENCY   = 1,
    parameter int INIT_ZERO      = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    output logic                      wr_ready_o,
    input  logic [SRAM_DEPTH_BIT-1:0] wr_addr_i,
    input  logic [SRAM_WIDTH/8-1:0]   wr_be_i,
    input  logic [SRAM_WIDTH-1:0]     wr_data_i,
    input  logic                      rd_en_i,
    output logic                      rd_ready_o,
    input  logic [SRAM_DEPTH_BIT-1:0] rd_addr_i,
    output logic [SRAM_WIDTH-1:0]     rd_data_o,
    output logic                      rd_valid_o,
    output logic                      init_done_o,
    output logic [15:0]               conflict_cnt_o
);

    localparam int ROW_BIT   = SRAM_DEPTH_BIT - NUM_BANK_BIT;
    localparam int NUM_BANKS = 1 << NUM_BANK_BIT;
    localparam int NUM_ROWS  = 1 << ROW_BIT;
    localparam int BE_W      = SRAM_WIDTH / 8;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("sram_banked_pipe: READ_LATENCY must be in 1..4");
    end
    if (NUM_BANK_BIT < 1 || NUM_BANK_BIT >= SRAM_DEPTH_BIT) begin : g_bad_banks
        $error("sram_banked_pipe: NUM_BANK_BIT must be in 1..SRAM_DEPTH_BIT-1");
    end
    if (SRAM_WIDTH % 8 != 0) begin : g_bad_width
        $error("sram_banked_pipe: SRAM_WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        INIT_CLR,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ROW_BIT-1:0]      row_q, row_d;
    logic                    init_done_q;
    logic [15:0]             conflict_cnt_q;
    logic [SRAM_WIDTH-1:0]   mem [NUM_BANKS][NUM_ROWS];
    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [SRAM_WIDTH-1:0]   pipe_data_q [READ_LATENCY];

    logic [NUM_BANK_BIT-1:0] wr_bank, rd_bank;
    logic [ROW_BIT-1:0]      wr_row, rd_row;
    logic                    run, conflict, wr_accept, rd_accept;

    assign wr_bank = wr_addr_i[NUM_BANK_BIT-1:0];
    assign wr_row  = wr_addr_i[SRAM_DEPTH_BIT-1:NUM_BANK_BIT];
    assign rd_bank = rd_addr_i[NUM_BANK_BIT-1:0];
    assign rd_row  = rd_addr_i[SRAM_DEPTH_BIT-1:NUM_BANK_BIT];

    // The write always wins a same-bank collision; the reader is expected to hold and retry.
    assign run       = (state_q == RUN) && !rst_i;
    assign conflict  = run && rd_en_i && wr_en_i && (rd_bank == wr_bank);
    assign wr_accept = run && wr_en_i;
    assign rd_accept = run && rd_en_i && !conflict;

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            INIT_CLR: begin
                row_d = row_q + ROW_BIT'(1);
                if (&row_q) state_d = RUN;
            end
            RUN:      state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= (INIT_ZERO != 0) ? INIT_CLR : RUN;
            row_q          <= '0;
            init_done_q    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            init_done_q <= (state_d == RUN);
            if (conflict && conflict_cnt_q != 16'hFFFF) conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    // NOTE: the array itself has no reset; only the fill sequence clears it, as real SRAM would.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == INIT_CLR) begin
            for (int b = 0; b < NUM_BANKS; b++) mem[b][row_q] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be_i[i]) mem[wr_bank][wr_row][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    // Data in each stage only moves with a valid, so the last stage holds between pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) pipe_data_q[k] <= '0;
        end else begin
            pipe_valid_q[0] <= rd_accept;
            if (rd_accept) pipe_data_q[0] <= mem[rd_bank][rd_row];
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_q[k] <= pipe_valid_q[k-1];
                if (pipe_valid_q[k-1]) pipe_data_q[k] <= pipe_data_q[k-1];
            end
        end
    end

    assign wr_ready_o     = run;
    assign rd_ready_o     = run && !conflict;
    assign rd_valid_o     = pipe_valid_q[READ_LATENCY-1];
    assign rd_data_o      = pipe_data_q[READ_LATENCY-1];
    assign init_done_o    = init_done_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_sram_banked_pipe.sv
// Scoreboard bench: three instances (read latency 1, 2, 3) share one directed stimulus stream;
// a monitor pops expected reads per instance and checks both data and arrival cycle.
module tb_sram_banked_pipe;

    localparam int NLANE = 3;

    typedef struct {
        logic [63:0] data;
        int          edge_n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;

    logic        wr_ready     [NLANE];
    logic        rd_ready     [NLANE];
    logic [63:0] rd_data      [NLANE];
    logic        rd_valid     [NLANE];
    logic        init_done    [NLANE];
    logic [15:0] conflict_cnt [NLANE];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   head [NLANE] = '{0, 0, 0};

    for (genvar g = 0; g < NLANE; g++) begin : g_dut
        sram_banked_pipe #(
            .SRAM_DEPTH_BIT(10),
            .NUM_BANK_BIT  (2),
            .SRAM_WIDTH    (64),
            .READ_LATENCY  (g + 1),
            .INIT_ZERO     (1)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .wr_en_i       (wr_en),
            .wr_ready_o    (wr_ready[g]),
            .wr_addr_i     (wr_addr),
            .wr_be_i       (wr_be),
            .wr_data_i     (wr_data),
            .rd_en_i       (rd_en),
            .rd_ready_o    (rd_ready[g]),
            .rd_addr_i     (rd_addr),
            .rd_data_o     (rd_data[g]),
            .rd_valid_o    (rd_valid[g]),
            .init_done_o   (init_done[g]),
            .conflict_cnt_o(conflict_cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Lane k has latency k+1, so a read accepted at edge A must appear right after edge A+k.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int k = 0; k < NLANE; k++) begin
                if (rst) head[k] = sb.size();
                if (rd_valid[k]) begin
                    if (head[k] < sb.size()) begin
                        check($sformatf("rd_data lane%0d", k), rd_data[k], sb[head[k]].data);
                        check($sformatf("rd_cycle lane%0d", k), 64'(cyc), 64'(sb[head[k]].edge_n + k));
                        head[k]++;
                    end else begin
                        check($sformatf("unexpected rd_valid lane%0d", k), 64'(rd_valid[k]), 64'd0);
                    end
                end else if (head[k] < sb.size() && sb[head[k]].edge_n + k < cyc) begin
                    check($sformatf("missing rd_valid lane%0d", k), 64'(rd_valid[k]), 64'd1);
                    head[k]++;
                end
            end
        end
    end

    task automatic idle(input int n);
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One cycle of requests; readies are checked mid-cycle and expected reads go to the scoreboard.
    task automatic op(input logic we, input logic [9:0] wa, input logic [7:0] be, input logic [63:0] wd,
                      input logic re, input logic [9:0] ra, input logic rd_rdy_exp,
                      input logic [63:0] rd_exp, input string tag);
        exp_t e;
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        #1;
        for (int k = 0; k < NLANE; k++) begin
            check($sformatf("%s wr_ready lane%0d", tag, k), 64'(wr_ready[k]), 64'd1);
            check($sformatf("%s rd_ready lane%0d", tag, k), 64'(rd_ready[k]), 64'(rd_rdy_exp));
        end
        if (re && rd_rdy_exp) begin
            e.data   = rd_exp;
            e.edge_n = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NLANE; k++) begin
            check($sformatf("%s rd_valid lane%0d", tag, k), 64'(rd_valid[k]), 64'd0);
            check($sformatf("%s rd_data lane%0d", tag, k), rd_data[k], 64'd0);
            check($sformatf("%s init_done lane%0d", tag, k), 64'(init_done[k]), 64'd0);
            check($sformatf("%s wr_ready lane%0d", tag, k), 64'(wr_ready[k]), 64'd0);
            check($sformatf("%s rd_ready lane%0d", tag, k), 64'(rd_ready[k]), 64'd0);
            check($sformatf("%s conflict_cnt lane%0d", tag, k), 64'(conflict_cnt[k]), 64'd0);
        end
    endtask

    // Releases reset and checks init_done rises on exactly the 256th edge after release.
    task automatic release_and_fill(input string tag);
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 10'h3FF;
        wr_be   = 8'hFF;
        wr_data = '1;
        rd_en   = 1'b1;
        rd_addr = 10'h001;
        #1;
        for (int k = 0; k < NLANE; k++) begin
            check($sformatf("%s fill wr_ready lane%0d", tag, k), 64'(wr_ready[k]), 64'd0);
            check($sformatf("%s fill rd_ready lane%0d", tag, k), 64'(rd_ready[k]), 64'd0);
        end
        idle(255);
        for (int k = 0; k < NLANE; k++)
            check($sformatf("%s init_done@255 lane%0d", tag, k), 64'(init_done[k]), 64'd0);
        idle(1);
        for (int k = 0; k < NLANE; k++)
            check($sformatf("%s init_done@256 lane%0d", tag, k), 64'(init_done[k]), 64'd1);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");

        // Fill timing, then the highest address reads back zero one cycle after acceptance.
        release_and_fill("init");
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'h3FF, 1'b1, 64'd0, "t1_rd3ff");

        // Byte mask: only the low four bytes are replaced.
        op(1'b1, 10'd5, 8'hFF, 64'h1122334455667788, 1'b0, 10'd0, 1'b1, 64'd0, "t2_wr_full");
        op(1'b1, 10'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 10'd0, 1'b1, 64'd0, "t2_wr_mask");
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'd5, 1'b1, 64'h11223344AAAAAAAA, "t2_rd5");

        // Different banks proceed together without touching the conflict counter.
        op(1'b1, 10'd1, 8'hFF, 64'h0000000000001111, 1'b0, 10'd0, 1'b1, 64'd0, "t3_wr1");
        op(1'b1, 10'd12, 8'hFF, 64'hC0C0C0C0C0C0C0C0, 1'b0, 10'd0, 1'b1, 64'd0, "t3_wr12");
        op(1'b1, 10'd4, 8'hFF, 64'hDEADBEEF00000004, 1'b1, 10'd1, 1'b1, 64'h0000000000001111, "t3_par");
        for (int k = 0; k < NLANE; k++)
            check($sformatf("t3 conflict_cnt lane%0d", k), 64'(conflict_cnt[k]), 64'd0);
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'd4, 1'b1, 64'hDEADBEEF00000004, "t3_rd4");

        // Same-bank collision for three cycles: write wins, read retried on the fourth.
        repeat (3) op(1'b1, 10'd8, 8'hFF, 64'h8888888888888888, 1'b1, 10'd12, 1'b0, 64'd0, "t4_conf");
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'd12, 1'b1, 64'hC0C0C0C0C0C0C0C0, "t4_retry");
        for (int k = 0; k < NLANE; k++)
            check($sformatf("t4 conflict_cnt lane%0d", k), 64'(conflict_cnt[k]), 64'd3);
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'd8, 1'b1, 64'h8888888888888888, "t4_rd8");

        // Back-to-back reads of addresses 0..7 holding 0x01..01 * (addr+1).
        for (int i = 0; i < 8; i++)
            op(1'b1, 10'(i), 8'hFF, 64'h0101010101010101 * 64'(i + 1), 1'b0, 10'd0, 1'b1, 64'd0, "t5_wr");
        for (int i = 0; i < 8; i++)
            op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'(i), 1'b1, 64'h0101010101010101 * 64'(i + 1), "t5_rd");
        idle(5);
        for (int k = 0; k < NLANE; k++) begin
            check($sformatf("t5 held rd_data lane%0d", k), rd_data[k], 64'h0808080808080808);
            check($sformatf("t5 idle rd_valid lane%0d", k), 64'(rd_valid[k]), 64'd0);
        end

        // Reset right after an accepted read: only the latency-1 lane delivers it.
        op(1'b1, 10'h3FF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 10'd0, 1'b1, 64'd0, "t6_wr3ff");
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'd5, 1'b1, 64'h0606060606060606, "t6_rd5");
        rst = 1'b1;
        idle(2);
        check_reset_state("t6_reset");
        rst = 1'b0;
        idle(100);
        for (int k = 0; k < NLANE; k++)
            check($sformatf("t6 mid-fill init_done lane%0d", k), 64'(init_done[k]), 64'd0);
        rst = 1'b1;
        idle(1);
        release_and_fill("refill");
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'h3FF, 1'b1, 64'd0, "t6_rd3ff");
        op(1'b0, 10'd0, 8'h00, 64'd0, 1'b1, 10'd5, 1'b1, 64'd0, "t6_rd5_cleared");
        idle(6);

        for (int k = 0; k < NLANE; k++)
            check($sformatf("drain pending lane%0d", k), 64'(sb.size() - head[k]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sram_banked_pipe.md
Name: sram_banked_pipe

Overview:
Parametrised successor to the team's single-port simulation SRAM. The array is split into 2^NUM_BANK_BIT address-interleaved banks, so one read and one write can be accepted in the same cycle when they target different banks. Writes take a per-byte write mask. Read latency is configurable and reads carry a valid flag. An optional post-reset zero-fill state machine is included. It serves as the on-chip activation/weight buffer model for the PE array.

Parameters:
SRAM_DEPTH_BIT, 10, total word-address bits (depth = 2^SRAM_DEPTH_BIT words)
NUM_BANK_BIT, 2, log2 of bank count; must be less than SRAM_DEPTH_BIT
SRAM_WIDTH, 64, word width in bits; must be a multiple of 8
READ_LATENCY, 1, cycles from read acceptance to rd_valid; legal range 1..4
INIT_ZERO, 1, 1 = zero-fill the whole array after reset; 0 = no fill

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
wr_ready  out  1  write accepted when wr_en && wr_ready
wr_addr  in  SRAM_DEPTH_BIT  write word address
wr_be  in  SRAM_WIDTH/8  byte enables; bit i covers data bits [8i+7:8i]
wr_data  in  SRAM_WIDTH  write data
rd_en  in  1  read request
rd_ready  out  1  read accepted when rd_en && rd_ready
rd_addr  in  SRAM_DEPTH_BIT  read word address
rd_data  out  SRAM_WIDTH  read data, held between valids
rd_valid  out  1  one-cycle pulse per accepted read
init_done  out  1  high once the array is usable
conflict_cnt  out  16  saturating count of cycles in which a read was refused for a bank conflict

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Address split:
  - bank = addr[NUM_BANK_BIT-1:0]
  - row = addr[SRAM_DEPTH_BIT-1:NUM_BANK_BIT]
- Each bank is a single-port array of 2^(SRAM_DEPTH_BIT-NUM_BANK_BIT) rows; it performs at most one read or one write per cycle.
- FSM states are INIT_CLR and RUN.
  - Reset goes to INIT_CLR if INIT_ZERO=1, otherwise to RUN.
  - INIT_CLR: a row counter runs 0 .. rows-1 and writes zero to that row in all banks in parallel. It takes exactly 2^(SRAM_DEPTH_BIT-NUM_BANK_BIT) cycles, then moves to RUN.
  - RUN: terminal state until the next rst.
- init_done = (state==RUN), registered.
- While rst is high or state is INIT_CLR: wr_ready=0, rd_ready=0, and requests are ignored.
- Write: on acceptance, only the bytes with wr_be=1 are updated at the edge; wr_be=0 leaves the word unchanged.
- Bank conflict: rd_en, wr_en and bank(rd_addr)==bank(wr_addr) all true in RUN.
  - The write wins and rd_ready=0 that cycle.
  - rd_ready is combinational from the current inputs and state; there is no buffering of refused reads. The requester holds rd_en/rd_addr and retries.
  - wr_ready is 1 in RUN regardless of reads.
- Read latency: an accepted read in cycle N samples the array at edge N.
  - rd_data and rd_valid present it after edge N+READ_LATENCY-1, i.e. READ_LATENCY=1 gives valid in cycle N+1.
  - Extra latency stages form a shift register of {valid, data}.
  - Back-to-back reads sustain one per cycle.
- Read-during-write to the same address is impossible in one cycle (same bank means conflict). A read accepted the cycle after a write returns the new data.
- conflict_cnt:
  - Increments in each RUN cycle where the conflict condition holds.
  - Saturates at 0xFFFF.
  - Cleared only by rst.
- Reset values: rd_data=0, rd_valid=0, all pipeline valids=0, conflict_cnt=0, init_done=0, wr_ready=0, rd_ready=0.
  - Array contents are not reset by rst alone; only the INIT_CLR fill clears them.
- Reset mid-operation: in-flight reads are dropped and no rd_valid is emitted for them. Reset during INIT_CLR restarts the fill at row 0.
- Illegal READ_LATENCY or NUM_BANK_BIT values: elaboration error (generate-time check).

Test Plan:
1. Reset fill, defaults (256 rows): assert rst for 2 cycles, then release -> init_done rises exactly 256 cycles after release. A read of addr 0x3FF then returns 0 with rd_valid one cycle after acceptance.
2. Byte mask: write 0x1122334455667788 to addr 5 with be=0xFF, then write 0xAAAAAAAAAAAAAAAA with be=0x0F, then read addr 5 -> rd_data=0x11223344AAAAAAAA.
3. Parallel different banks: wr addr 4 (bank 0) and rd addr 1 (bank 1) in the same cycle -> both ready=1, conflict_cnt unchanged.
4. Conflict: wr addr 8 and rd addr 12 (both bank 0) for 3 cycles, then wr_en drops.
   - rd_ready=0 for those 3 cycles, 1 on the 4th.
   - conflict_cnt=3.
   - Exactly one rd_valid.
5. READ_LATENCY=3, 8 back-to-back reads of addr 0..7 -> 8 consecutive rd_valid pulses, the first 3 cycles after the first acceptance, data in order.
6. Assert rst one cycle after a read is accepted with READ_LATENCY=2 -> no rd_valid follows, conflict_cnt=0, and the fill restarts.
